// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_pkg;

   localparam int SEG_NUM_DIGITS = 4;
   localparam int SEG_NIBBLE_W   = 4;

   // Bits needed to hold the values 0..n-1. Returns at least 1 so that
   // single-entry counters still get a real register.
   function automatic int seg_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

   localparam int SEG_IDX_W = seg_clog2(SEG_NUM_DIGITS);

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler: counts clk cycles within one digit slot and flags the
// last cycle of the slot and the anti-ghosting blank window at its start.
module seg_scan_timer
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   output logic [seg_clog2(REFRESH_DIV)-1:0]    div_cnt,
   output logic                                 slot_wrap,
   output logic                                 blank_active
);

   localparam int               CNT_W     = seg_clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   assign slot_wrap    = (div_cnt == LAST_CNT);
   assign blank_active = (div_cnt < BLANK_END);

   // Free-running slot counter, 0..REFRESH_DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (slot_wrap) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-select 7-segment
// display. Holds a shadowed display value that only changes at frame
// boundaries, and per slot presents one nibble plus its one-hot com line.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = SEG_NUM_DIGITS,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   en,
   input  logic                                   lz_en,
   input  logic                                   load,
   input  logic [SEG_NIBBLE_W*NUM_DIGITS-1:0]     value,
   output logic [SEG_NIBBLE_W-1:0]                digit_code,
   output logic [NUM_DIGITS-1:0]                  com,
   output logic [seg_clog2(NUM_DIGITS)-1:0]       digit_idx,
   output logic                                   frame_start
);

   localparam int               VAL_W    = SEG_NIBBLE_W * NUM_DIGITS;
   localparam int               IDX_W    = seg_clog2(NUM_DIGITS);
   localparam int               CNT_W    = seg_clog2(REFRESH_DIV);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        div_cnt;
   logic                    slot_wrap;
   logic                    blank_active;
   logic                    frame_wrap;
   logic [IDX_W-1:0]        slot;
   logic [VAL_W-1:0]        pend_val;
   logic                    pend_vld;
   logic [VAL_W-1:0]        disp_val;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    zero_above;
   logic [SEG_NIBBLE_W-1:0] cur_nib;
   logic [NUM_DIGITS-1:0]   cur_com;

   seg_scan_timer #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .div_cnt      (div_cnt),
      .slot_wrap    (slot_wrap),
      .blank_active (blank_active)
   );

   // Last cycle of the last digit slot: the only point where disp_val moves.
   assign frame_wrap = slot_wrap && (slot == LAST_IDX);

   // Digit slot index, advanced on every slot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (slot_wrap) begin
         slot <= (slot == LAST_IDX) ? '0 : slot + 1'b1;
      end
   end

   // Shadow/display pair: loads park in pend_val until the frame boundary.
   // A load landing on the boundary cycle itself is taken straight into
   // disp_val, and any older pending value is dropped with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val <= '0;
         pend_vld <= 1'b0;
         disp_val <= '0;
      end else if (frame_wrap) begin
         if (load) begin
            disp_val <= value;
         end else if (pend_vld) begin
            disp_val <= pend_val;
         end
         pend_vld <= 1'b0;
      end else if (load) begin
         pend_val <= value;
         pend_vld <= 1'b1;
      end
   end

   // Leading-zero mask: digit i>0 is blank when it and every higher nibble
   // are zero. Digit 0 is never masked so a zero value still shows "0".
   always_comb begin
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         if (disp_val[i*SEG_NIBBLE_W +: SEG_NIBBLE_W] != '0) begin
            zero_above = 1'b0;
         end
         lz_mask[i] = zero_above;
      end
   end

   // Nibble and com line for the current slot.
   always_comb begin
      cur_nib = '0;
      cur_com = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (slot == IDX_W'(i)) begin
            cur_nib    = disp_val[i*SEG_NIBBLE_W +: SEG_NIBBLE_W];
            cur_com[i] = en && !blank_active && !(lz_en && lz_mask[i]);
         end
      end
   end

   // Registered outputs; com clears asynchronously with reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_code  <= '0;
         com         <= '0;
         digit_idx   <= '0;
         frame_start <= 1'b0;
      end else begin
         digit_code  <= cur_nib;
         com         <= cur_com;
         digit_idx   <= slot;
         frame_start <= (slot == '0) && (div_cnt == '0);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYCLES=1 (one frame = 16 cycles).
module tb_seg_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        lz_en;
   logic        load;
   logic [15:0] value;
   logic [3:0]  digit_code;
   logic [3:0]  com;
   logic [1:0]  digit_idx;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   seg_scan_ctrl #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .lz_en       (lz_en),
      .load        (load),
      .value       (value),
      .digit_code  (digit_code),
      .com         (com),
      .digit_idx   (digit_idx),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out(input string tag, input logic [3:0] ecode,
                            input logic [3:0] ecom, input logic efs,
                            input logic [1:0] eidx);
      checks++;
      assert (digit_code === ecode) else begin
         errors++;
         $error("FAIL %s digit_code: got %h expected %h", tag, digit_code, ecode);
      end
      checks++;
      assert (com === ecom) else begin
         errors++;
         $error("FAIL %s com: got %b expected %b", tag, com, ecom);
      end
      checks++;
      assert (frame_start === efs) else begin
         errors++;
         $error("FAIL %s frame_start: got %b expected %b", tag, frame_start, efs);
      end
      checks++;
      assert (digit_idx === eidx) else begin
         errors++;
         $error("FAIL %s digit_idx: got %0d expected %0d", tag, digit_idx, eidx);
      end
   endtask

   // Checks one 4-cycle slot: first cycle blanked, then pat. Optionally
   // pulses load so it is sampled on cycle ld_c of this slot.
   task automatic check_slot(input string tag, input logic [1:0] idx,
                             input logic [3:0] code, input logic [3:0] pat,
                             input int ld_c, input logic [15:0] ld_v);
      for (int c = 0; c < 4; c++) begin
         if (c == ld_c) begin
            load  = 1'b1;
            value = ld_v;
         end
         @(negedge clk);
         load = 1'b0;
         check_out($sformatf("%s s%0d c%0d", tag, idx, c), code,
                   (c == 0) ? 4'b0000 : pat, (idx == 2'd0) && (c == 0), idx);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      lz_en = 1'b0;
      load  = 1'b0;
      value = 16'h0;

      // reset held for three cycles
      repeat (3) @(negedge clk);
      check_out("reset", 4'h0, 4'b0000, 1'b0, 2'd0);
      en    = 1'b1;
      rst_n = 1'b1;

      // F0: display 0, load 0x1234 mid-frame
      check_slot("f0", 2'd0, 4'h0, 4'b0001, 0, 16'h1234);
      check_slot("f0", 2'd1, 4'h0, 4'b0010, -1, 16'h0);
      check_slot("f0", 2'd2, 4'h0, 4'b0100, -1, 16'h0);
      check_slot("f0", 2'd3, 4'h0, 4'b1000, -1, 16'h0);

      // F1: scan order of 0x1234
      check_slot("scan", 2'd0, 4'h4, 4'b0001, -1, 16'h0);
      check_slot("scan", 2'd1, 4'h3, 4'b0010, -1, 16'h0);
      check_slot("scan", 2'd2, 4'h2, 4'b0100, -1, 16'h0);
      check_slot("scan", 2'd3, 4'h1, 4'b1000, -1, 16'h0);

      // F2: loads in slots 2 and 3 must not tear the current frame
      check_slot("tear", 2'd0, 4'h4, 4'b0001, -1, 16'h0);
      check_slot("tear", 2'd1, 4'h3, 4'b0010, -1, 16'h0);
      check_slot("tear", 2'd2, 4'h2, 4'b0100, 0, 16'hABCD);
      check_slot("tear", 2'd3, 4'h1, 4'b1000, 0, 16'h5678);

      // F3: last load wins; queue 0x0042 for the next frame
      lz_en = 1'b1;
      check_slot("last", 2'd0, 4'h8, 4'b0001, -1, 16'h0);
      check_slot("last", 2'd1, 4'h7, 4'b0010, 1, 16'h0042);
      check_slot("last", 2'd2, 4'h6, 4'b0100, -1, 16'h0);
      check_slot("last", 2'd3, 4'h5, 4'b1000, -1, 16'h0);

      // F4: 0x0042 with leading-zero suppression; 0x0999 pending, then
      // a boundary-cycle load of 0x0000 that must replace it
      check_slot("lz42", 2'd0, 4'h2, 4'b0001, -1, 16'h0);
      check_slot("lz42", 2'd1, 4'h4, 4'b0010, -1, 16'h0);
      check_slot("lz42", 2'd2, 4'h0, 4'b0000, 0, 16'h0999);
      check_slot("lz42", 2'd3, 4'h0, 4'b0000, 3, 16'h0000);

      // F5: zero value, only digit 0 lit
      check_slot("lz0", 2'd0, 4'h0, 4'b0001, -1, 16'h0);
      check_slot("lz0", 2'd1, 4'h0, 4'b0000, -1, 16'h0);
      check_slot("lz0", 2'd2, 4'h0, 4'b0000, -1, 16'h0);
      check_slot("lz0", 2'd3, 4'h0, 4'b0000, -1, 16'h0);

      // F6/F7: display disabled, scanning and loading continue
      lz_en = 1'b0;
      en    = 1'b0;
      check_slot("en0a", 2'd0, 4'h0, 4'b0000, -1, 16'h0);
      check_slot("en0a", 2'd1, 4'h0, 4'b0000, 0, 16'h00F0);
      check_slot("en0a", 2'd2, 4'h0, 4'b0000, -1, 16'h0);
      check_slot("en0a", 2'd3, 4'h0, 4'b0000, -1, 16'h0);
      check_slot("en0b", 2'd0, 4'h0, 4'b0000, -1, 16'h0);
      check_slot("en0b", 2'd1, 4'hF, 4'b0000, -1, 16'h0);
      check_slot("en0b", 2'd2, 4'h0, 4'b0000, -1, 16'h0);
      check_slot("en0b", 2'd3, 4'h0, 4'b0000, -1, 16'h0);

      // F8: enabled again, 0x7777 left pending, reset lands in slot 2
      en = 1'b1;
      check_slot("en1", 2'd0, 4'h0, 4'b0001, 0, 16'h7777);
      check_slot("en1", 2'd1, 4'hF, 4'b0010, -1, 16'h0);
      @(negedge clk);
      check_out("en1 s2 c0", 4'h0, 4'b0000, 1'b0, 2'd2);
      @(negedge clk);
      check_out("en1 s2 c1", 4'h0, 4'b0100, 1'b0, 2'd2);

      #2 rst_n = 1'b0;
      #1 check_out("async rst", 4'h0, 4'b0000, 1'b0, 2'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Two frames after reset: value 0, pending 0x7777 discarded
      for (int f = 0; f < 2; f++) begin
         check_slot("postrst", 2'd0, 4'h0, 4'b0001, -1, 16'h0);
         check_slot("postrst", 2'd1, 4'h0, 4'b0010, -1, 16'h0);
         check_slot("postrst", 2'd2, 4'h0, 4'b0100, -1, 16'h0);
         check_slot("postrst", 2'd3, 4'h0, 4'b1000, -1, 16'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
